// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Raster timing generator for a VGA-style display. A clock divider produces
// one pixel-advance strobe every CLK_DIV system clocks; on each strobe the
// horizontal pixel counter advances, and on its wrap the line counter
// advances. Visible-area and sync flags are decoded from the counters' next
// values and registered, so they always change on the same edge as the
// counters.
//
// Ports
//   clock        in   system clock, all state updates on its rising edge
//   rst_n        in   asynchronous active-low reset
//   pxcount      out  [10:0] current horizontal pixel position
//   linecount    out  [10:0] current line position
//   bright       out  current position lies in the visible area
//   hsync        out  horizontal sync, active-low
//   vsync        out  vertical sync, active-low
//   pix_en       out  one-clock strobe in each pixel-advance clock
//   frame_start  out  one-clock pulse after the counters advance to (0,0)
// -----------------------------------------------------------------------------
module vga_timing #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic        clock,
    input  logic        rst_n,
    output logic [10:0] pxcount,
    output logic [10:0] linecount,
    output logic        bright,
    output logic        hsync,
    output logic        vsync,
    output logic        pix_en,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

    localparam logic [10:0] CNT_ZERO = 11'd0;
    localparam logic [10:0] CNT_ONE  = 11'd1;
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

    // Reject geometries whose counters would not fit in 11 bits.
    if (CLK_DIV < 1 || H_TOTAL > 2048 || V_TOTAL > 2048 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_params
        $error("vga_timing: illegal parameter set");
    end

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_next_s;
    logic             div_last_s;
    logic [10:0]      px_r;
    logic [10:0]      ln_r;
    logic [10:0]      px_next_s;
    logic [10:0]      ln_next_s;
    logic             bright_r;
    logic             hsync_r;
    logic             vsync_r;
    logic             frame_start_r;
    logic             bright_s;
    logic             hsync_s;
    logic             vsync_s;
    logic             frame_start_s;

    // Divider next value and the pixel-advance condition.
    always_comb begin
        div_last_s = (div_r == DIV_LAST);
        if (div_last_s) begin
            div_next_s = DIV_ZERO;
        end else begin
            div_next_s = div_r + DIV_ONE;
        end
    end

    // Next raster position: pixel wraps at H_TOTAL-1, line advances only on that wrap.
    always_comb begin
        px_next_s = px_r;
        ln_next_s = ln_r;
        if (div_last_s) begin
            if (px_r == H_LAST) begin
                px_next_s = CNT_ZERO;
                if (ln_r == V_LAST) begin
                    ln_next_s = CNT_ZERO;
                end else begin
                    ln_next_s = ln_r + CNT_ONE;
                end
            end else begin
                px_next_s = px_r + CNT_ONE;
                ln_next_s = ln_r;
            end
        end else begin
            px_next_s = px_r;
            ln_next_s = ln_r;
        end
    end

    // Decode visible area, syncs and frame start from the next position.
    always_comb begin
        bright_s      = (px_next_s < H_VIS) && (ln_next_s < V_VIS);
        hsync_s       = !((px_next_s >= HS_START) && (px_next_s < HS_END));
        vsync_s       = !((ln_next_s >= VS_START) && (ln_next_s < VS_END));
        frame_start_s = div_last_s && (px_next_s == CNT_ZERO) && (ln_next_s == CNT_ZERO);
    end

    // Divider, counters and decoded flags; reset parks the raster on its last position.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            div_r         <= DIV_ZERO;
            px_r          <= H_LAST;
            ln_r          <= V_LAST;
            bright_r      <= 1'b0;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            frame_start_r <= 1'b0;
        end else begin
            div_r         <= div_next_s;
            px_r          <= px_next_s;
            ln_r          <= ln_next_s;
            bright_r      <= bright_s;
            hsync_r       <= hsync_s;
            vsync_r       <= vsync_s;
            frame_start_r <= frame_start_s;
        end
    end

    assign pxcount     = px_r;
    assign linecount   = ln_r;
    assign bright      = bright_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign frame_start = frame_start_r;

    // The strobe is decoded straight from the divider register so it is high in
    // the very clock the counters are about to advance. Gating with rst_n keeps
    // it low during reset even when CLK_DIV=1 makes the divider permanently "last".
    assign pix_en = rst_n & div_last_s;

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
// Self-checking bench for vga_timing. Three instances (default VGA geometry,
// a tiny CLK_DIV=1 geometry and a tiny CLK_DIV=3 geometry) share clock and
// reset. A reference model derives every output from the number of clock
// edges since reset release using plain division and modulo arithmetic.
// Random run lengths are separated by asynchronous resets at random phases.
// -----------------------------------------------------------------------------
module tb_vga_timing;

    typedef struct packed {
        logic [10:0] px;
        logic [10:0] ln;
        logic        bright;
        logic        hs;
        logic        vs;
        logic        pe;
        logic        fs;
    } obs_t;

    logic clk;
    logic rst_n;

    logic [10:0] px_a, ln_a, px_b, ln_b, px_c, ln_c;
    logic br_a, hs_a, vs_a, pe_a, fs_a;
    logic br_b, hs_b, vs_b, pe_b, fs_b;
    logic br_c, hs_c, vs_c, pe_c, fs_c;

    obs_t obs_a, obs_b, obs_c;

    int n_checks;
    int n_errors;
    int k;
    bit first_seg;
    int hs_low_cnt;
    int br_low_cnt;
    int first_hs_px;
    int last_fs_b;
    int last_fs_c;

    vga_timing dut_a (
        .clock(clk), .rst_n(rst_n), .pxcount(px_a), .linecount(ln_a),
        .bright(br_a), .hsync(hs_a), .vsync(vs_a), .pix_en(pe_a), .frame_start(fs_a)
    );

    vga_timing #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_b (
        .clock(clk), .rst_n(rst_n), .pxcount(px_b), .linecount(ln_b),
        .bright(br_b), .hsync(hs_b), .vsync(vs_b), .pix_en(pe_b), .frame_start(fs_b)
    );

    vga_timing #(
        .CLK_DIV(3), .H_VISIBLE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(3), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_c (
        .clock(clk), .rst_n(rst_n), .pxcount(px_c), .linecount(ln_c),
        .bright(br_c), .hsync(hs_c), .vsync(vs_c), .pix_en(pe_c), .frame_start(fs_c)
    );

    assign obs_a = {px_a, ln_a, br_a, hs_a, vs_a, pe_a, fs_a};
    assign obs_b = {px_b, ln_b, br_b, hs_b, vs_b, pe_b, fs_b};
    assign obs_c = {px_c, ln_c, br_c, hs_c, vs_c, pe_c, fs_c};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    // Expected outputs after 'edges' clock edges since reset release.
    function automatic obs_t model(input int edges, input bit in_rst, input int cd,
                                   input int hv, input int hf, input int hsw, input int hb,
                                   input int vv, input int vf, input int vsw, input int vb);
        int ht, vt, adv, lin, px, ln;
        obs_t o;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (in_rst) begin
            o.px = 11'(ht - 1); o.ln = 11'(vt - 1);
            o.bright = 1'b0; o.hs = 1'b1; o.vs = 1'b1; o.pe = 1'b0; o.fs = 1'b0;
        end else begin
            adv = edges / cd;
            lin = (adv + ht * vt - 1) % (ht * vt);
            px  = lin % ht;
            ln  = lin / ht;
            o.px     = 11'(px);
            o.ln     = 11'(ln);
            o.bright = (px < hv) && (ln < vv);
            o.hs     = !((px >= hv + hf) && (px < hv + hf + hsw));
            o.vs     = !((ln >= vv + vf) && (ln < vv + vf + vsw));
            o.pe     = ((edges % cd) == cd - 1);
            o.fs     = (adv >= 1) && (lin == 0) && ((edges % cd) == 0);
        end
        return o;
    endfunction

    task automatic check_all(input bit in_rst);
        check("dut_a", 32'(obs_a), 32'(model(k, in_rst, 4, 640, 16, 96, 48, 480, 10, 2, 33)));
        check("dut_b", 32'(obs_b), 32'(model(k, in_rst, 1, 8, 1, 2, 1, 4, 1, 1, 1)));
        check("dut_c", 32'(obs_c), 32'(model(k, in_rst, 3, 6, 2, 3, 2, 3, 1, 2, 1)));
    endtask

    // Advance n clocks with reset released, checking after each edge.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            check_all(1'b0);
            if (first_seg) begin
                if (k == 2) check("a_pix_en_early", 32'(pe_a), 32'd0);
                if (k == 3) check("a_pix_en_first", 32'(pe_a), 32'd1);
                if (k == 4) begin
                    check("a_first_px", 32'(px_a), 32'd0);
                    check("a_first_ln", 32'(ln_a), 32'd0);
                    check("a_first_bright", 32'(br_a), 32'd1);
                    check("a_first_fs", 32'(fs_a), 32'd1);
                end
                if (k >= 4 && k < 3204) begin
                    if (!hs_a) hs_low_cnt++;
                    if (!br_a) br_low_cnt++;
                    if (!hs_a && first_hs_px < 0) first_hs_px = int'(px_a);
                end
            end
            if (fs_b) begin
                if (last_fs_b >= 0) check("b_frame_period", 32'(k - last_fs_b), 32'd84);
                last_fs_b = k;
            end
            if (fs_c) begin
                if (last_fs_c >= 0) check("c_frame_period", 32'(k - last_fs_c), 32'd273);
                last_fs_c = k;
            end
        end
    endtask

    // Assert reset asynchronously between edges, check it takes effect at once, then release.
    task automatic do_reset(input int off);
        #(off);
        rst_n = 1'b0;
        #1;
        check_all(1'b1);
        @(posedge clk);
        @(negedge clk);
        check_all(1'b1);
        #2;
        rst_n = 1'b1;
        k = 0;
        last_fs_b = -1;
        last_fs_c = -1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        k           = 0;
        hs_low_cnt  = 0;
        br_low_cnt  = 0;
        first_hs_px = -1;
        last_fs_b   = -1;
        last_fs_c   = -1;
        first_seg   = 1'b1;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        check_all(1'b1);
        check("rst_pix_en_b", 32'(pe_b), 32'd0);
        #2;
        rst_n = 1'b1;

        run(3300);
        check("a_hsync_low_clocks", 32'(hs_low_cnt), 32'd384);
        check("a_bright_low_clocks", 32'(br_low_cnt), 32'd640);
        check("a_hsync_first_px", 32'(first_hs_px), 32'd656);
        first_seg = 1'b0;

        for (int s = 0; s < 25; s++) begin
            do_reset(int'($urandom_range(1, 3)));
            run(int'($urandom_range(5, 600)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
